// File: rtl/fir_pkg.sv
// Purpose: shared constants and FSM state type for the FIR coefficient loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

    localparam int DEF_SIZE        = 8;   // width of one coefficient on the coeffs bus
    localparam int DEF_NUM_COEFF   = 4;   // number of taps
    localparam int DEF_CW          = 5;   // width of the switch coefficient field
    localparam int DEF_SYNC_STAGES = 2;   // synchronizer depth

    localparam int SEL_W = $clog2(DEF_NUM_COEFF);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_TICK = 1'b1
    } state_t;

endpackage

// File: rtl/fir_coeff_loader_sync_edge.sv
// Purpose: multi-flop synchronizer for one slow level input plus registered rising-edge pulse.
// Latency: an input rise before edge 0 gives a one-cycle pulse after edge SYNC_STAGES.
// Backpressure: none; every rise produces exactly one pulse.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   d        : asynchronous level input
//   rise     : one-cycle pulse per synchronized rising edge
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
            // Registered so downstream logic sees a clean flop output.
            rise   <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// Purpose: switch-driven shadow coefficient bank, applied atomically to the active bank on sample_tick.
// Latency: load/commit act SYNC_STAGES+1 edges after the switch rises; bank applies on the edge sampling sample_tick.
// Backpressure: loads arriving while a commit is pending are dropped and flagged by load_rejected.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   coeff_in, sel : asynchronous coefficient value and shadow slot index
//   load, commit  : asynchronous switch levels; each rise is one request
//   sample_tick   : one-cycle pulse at the sample boundary
//   coeffs        : active bank, slot i at [i*SIZE +: SIZE]
//   dirty         : per-slot "written since last commit" flags
//   pending       : commit accepted, waiting for sample_tick
//   commit_done   : one-cycle pulse on the edge coeffs updates
//   load_rejected : one-cycle pulse when a load edge is dropped
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int SIZE        = DEF_SIZE,
    parameter int NUM_COEFF   = DEF_NUM_COEFF,
    parameter int CW          = DEF_CW,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CW-1:0]                coeff_in,
    input  logic [$clog2(NUM_COEFF)-1:0] sel,
    input  logic                         load,
    input  logic                         commit,
    input  logic                         sample_tick,
    output logic [NUM_COEFF*SIZE-1:0]    coeffs,
    output logic [NUM_COEFF-1:0]         dirty,
    output logic                         pending,
    output logic                         commit_done,
    output logic                         load_rejected
);

    localparam int SW = $clog2(NUM_COEFF);

    // Data and index synchronizer: a plain vector pipeline. The operator
    // holds these steady before pulling load, so no per-bit coherence issue.
    logic [CW+SW-1:0] vsync_q [SYNC_STAGES];
    logic [CW-1:0]    coeff_s;
    logic [SW-1:0]    sel_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) vsync_q[i] <= '0;
        end else begin
            vsync_q[0] <= {sel, coeff_in};
            for (int i = 1; i < SYNC_STAGES; i++) vsync_q[i] <= vsync_q[i-1];
        end
    end

    assign {sel_s, coeff_s} = vsync_q[SYNC_STAGES-1];

    logic load_rise;
    logic commit_rise;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (load),
        .rise (load_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_commit_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (commit),
        .rise (commit_rise)
    );

    // Out-of-range slot only possible when NUM_COEFF is not a power of two.
    logic sel_ok;
    generate
        if ((1 << SW) == NUM_COEFF) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_range
            assign sel_ok = (sel_s < SW'(NUM_COEFF));
        end
    endgenerate

    state_t state, next_state;
    logic   do_write, do_reject, do_apply;
    logic [NUM_COEFF*SIZE-1:0] shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_write   = 1'b0;
        do_reject  = 1'b0;
        do_apply   = 1'b0;
        case (state)
            IDLE: begin
                if (load_rise) begin
                    if (sel_ok) do_write  = 1'b1;
                    else        do_reject = 1'b1;
                end
                // A tick coinciding with the commit is deliberately not used:
                // the bank waits for the next full sample boundary.
                if (commit_rise && (dirty != '0)) next_state = WAIT_TICK;
            end
            WAIT_TICK: begin
                // Shadow is frozen while a commit is pending so the applied
                // bank is exactly what the operator committed.
                if (load_rise) do_reject = 1'b1;
                if (sample_tick) begin
                    do_apply   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow        <= '0;
            coeffs        <= '0;
            dirty         <= '0;
            commit_done   <= 1'b0;
            load_rejected <= 1'b0;
        end else begin
            commit_done   <= do_apply;
            load_rejected <= do_reject;
            if (do_write) begin
                shadow[sel_s*SIZE +: SIZE] <= SIZE'(coeff_s);
                dirty[sel_s]               <= 1'b1;
            end
            if (do_apply) begin
                coeffs <= shadow;
                dirty  <= '0;
            end
        end
    end

    assign pending = (state == WAIT_TICK);

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Upstream coefficient stage feeding the FIR datapath's coeffs bus. It synchronizes slow switch inputs, writes coefficients into a shadow bank one at a time, and applies the whole bank atomically to the active bank on the next sample boundary. This guarantees the filter never computes with a half-updated coefficient set.

Parameters:
SIZE, 8, width of one coefficient on the output bus
NUM_COEFF, 4, number of taps/coefficients
CW, 5, width of coefficient entry field; CW <= SIZE required
SYNC_STAGES, 2, flop stages in each input synchronizer (>= 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
coeff_in  input  CW  coefficient value from switches (asynchronous)
sel  input  $clog2(NUM_COEFF)  shadow slot index (asynchronous)
load  input  1  level from switch; each rising edge writes one shadow slot
commit  input  1  level from switch; each rising edge requests a bank update
sample_tick  input  1  one-cycle pulse when the sample shift register advances
coeffs  output  NUM_COEFF*SIZE  active bank; coefficient i at [i*SIZE +: SIZE]
dirty  output  NUM_COEFF  per-slot flag: shadow differs from last commit
pending  output  1  commit requested, waiting for sample_tick
commit_done  output  1  one-cycle pulse when active bank is updated
load_rejected  output  1  one-cycle pulse when a load edge is dropped

Behaviour:
- rst asserted: all synchronizer flops, edge-history flops, shadow bank, coeffs, and dirty clear to 0. pending, commit_done and load_rejected clear to 0. FSM goes to IDLE. Reset mid-commit discards the request.
- Sync: coeff_in, sel, load and commit each pass through SYNC_STAGES flops. Edge detect compares the last sync stage with a 1-flop history.
- Load latency: with SYNC_STAGES=2, a load rise before edge 0 writes the shadow on edge 3, i.e. SYNC_STAGES+1 edges. coeff_in/sel must be stable 2 cycles before load rises.
- Shadow write: shadow[sel_s] <= zero-extend(coeff_in_s) to SIZE; dirty[sel_s] <= 1. Rewriting the same value still sets dirty.
- FSM IDLE:
  - load edge -> shadow write.
  - commit edge with dirty != 0 -> WAIT_TICK, pending=1.
  - commit edge with dirty == 0 -> ignored, stay IDLE.
  - sample_tick in the same cycle as the commit edge does NOT apply the bank; the update waits for the next tick.
- FSM WAIT_TICK:
  - On sample_tick: coeffs <= shadow (all slots at once); dirty <= 0; pending <= 0; commit_done pulses for 1 cycle (registered, same edge as coeffs change); -> IDLE.
  - A load edge is dropped (shadow unchanged) and load_rejected pulses for 1 cycle.
  - A further commit edge is ignored.
  - A load edge in the same cycle as the applying sample_tick is also rejected.
- Slot order: coeffs is a flat bus; slot 0 is the LSBs. sel is the raw binary index; if NUM_COEFF is not a power of 2, sel >= NUM_COEFF is a rejected load.
- coeffs only changes on commit (or rst); it is never combinational from inputs.
- No arithmetic beyond zero-extension.

Decomposition:
- Shared package fir_pkg:
  - default SIZE, NUM_COEFF and CW constants
  - state enum {IDLE, WAIT_TICK}
  - localparam SEL_W = $clog2(NUM_COEFF)
- Sub-module sync_edge (parameter SYNC_STAGES): N-flop synchronizer plus rising-edge pulse output. Instantiate it for load and commit. Data and sel use a plain vector synchronizer inside the top.

Test Plan:
- rst pulse mid-run -> coeffs=0, dirty=0, pending=0 immediately (async), no commit_done.
- sel=2, coeff_in=5'h13, load rise -> dirty=4'b0100 after 3 edges; coeffs unchanged.
- Commit:
  - Load slots 0..3 with 1, 2, 3, 4, then commit rise -> pending=1.
  - 10 cycles later, sample_tick -> next edge coeffs=32'h04030201, commit_done single pulse, dirty=0, pending=0.
- Commit rise with dirty=0 -> pending stays 0, coeffs unchanged, no commit_done across 3 sample_ticks.
- In WAIT_TICK, load sel=1, coeff_in=5'h1F -> load_rejected pulse; after the tick, slot1=8'h02 not 8'h1F.
- commit edge and sample_tick in the same cycle -> no update on that tick; update occurs on the following tick.
